// File: rtl/bids22_pkg.sv
// Shared types for the bids22 command sequencer: opcodes, FSM states,
// error/winner codes and the packed FIFO entry.
package bids22_pkg;

    typedef enum logic [3:0] {
        OP_NOOP        = 4'h0,
        OP_UNLOCK      = 4'h1,
        OP_LOCK        = 4'h2,
        OP_LOADX       = 4'h3,
        OP_LOADY       = 4'h4,
        OP_LOADZ       = 4'h5,
        OP_SET_LIMIT   = 4'h6,
        OP_SET_ROUND   = 4'h7,
        OP_BID_CHARGE  = 4'h8,
        OP_START_ROUND = 4'hF
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CHECK,
        S_ROUND,
        S_WAIT_RES,
        S_HALT
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_AUCTION = 2'b01;
    localparam logic [1:0] ERR_BAD_OP  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_X    = 2'd1;
    localparam logic [1:0] WIN_Y    = 2'd2;
    localparam logic [1:0] WIN_Z    = 2'd3;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] data;
    } cmd_t;

    // Exactly one flag set names the winner; none or several is a tie.
    function automatic logic [1:0] winner_code(input logic x, input logic y, input logic z);
        case ({x, y, z})
            3'b100:  return WIN_X;
            3'b010:  return WIN_Y;
            3'b001:  return WIN_Z;
            default: return WIN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bids22_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with full/empty flags derived from
// a registered occupancy count.
module bids22_cmd_fifo
    import bids22_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [$bits(cmd_t)-1:0]  wr,
    input  logic                     pop,
    output logic [$bits(cmd_t)-1:0]  rd,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [$bits(cmd_t)-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    push_ok;
    logic                    pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count gates every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr;
    end

endmodule

// File: rtl/bids22_cmd_seq.sv
// bids22 command sequencer: replays queued host commands to the auction and
// collects round results. Optional BIDS_SEQ_TIMEOUT_EN bounds the result wait.
module bids22_cmd_seq
    import bids22_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    input  logic        seq_clr,
    input  logic        ready,
    input  logic [1:0]  err,
    input  logic        roundOver,
    input  logic [31:0] maxBid,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    output logic        res_valid,
    output logic [31:0] res_maxBid,
    output logic [1:0]  res_winner,
    output logic [1:0]  seq_err,
    output logic        busy
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("bids22_cmd_seq: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    seq_state_t state;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bad_op;
    logic [31:0] rcnt;

`ifdef BIDS_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tcnt;
`endif

    bids22_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wr    ({cmd_op, cmd_data}),
        .pop   (state == S_ISSUE),
        .rd    (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign bad_op    = (head.op > OP_BID_CHARGE) && (head.op != OP_START_ROUND);

    // NOTE: all FSM state and outputs update with non-blocking assignments in one clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            C_op       <= OP_NOOP;
            C_data     <= '0;
            C_start    <= 1'b0;
            res_valid  <= 1'b0;
            res_maxBid <= '0;
            res_winner <= WIN_NONE;
            seq_err    <= ERR_NONE;
            rcnt       <= '0;
`ifdef BIDS_SEQ_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            C_op      <= OP_NOOP;
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty && ready) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bad_op) begin
                        seq_err <= ERR_BAD_OP;
                        state   <= S_HALT;
                    end else if (head.op == OP_START_ROUND) begin
                        rcnt    <= (head.data == 32'd0) ? 32'd1 : head.data;
                        C_start <= 1'b1;
                        state   <= S_ROUND;
                    end else begin
                        C_op   <= head.op;
                        C_data <= head.data;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (err != 2'b00) begin
                        seq_err <= ERR_AUCTION;
                        state   <= S_HALT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ROUND: begin
                    // C_start was raised on entry, so dropping it at rcnt == 1 gives rcnt high cycles.
                    if (rcnt == 32'd1) begin
                        C_start <= 1'b0;
                        state   <= S_WAIT_RES;
`ifdef BIDS_SEQ_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end else begin
                        rcnt <= rcnt - 32'd1;
                    end
                end
                S_WAIT_RES: begin
                    if (roundOver) begin
                        res_maxBid <= maxBid;
                        res_winner <= winner_code(X_win, Y_win, Z_win);
                        res_valid  <= 1'b1;
                        state      <= S_IDLE;
                    end
`ifdef BIDS_SEQ_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        seq_err <= ERR_TIMEOUT;
                        state   <= S_HALT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                S_HALT: begin
                    if (seq_clr) begin
                        seq_err <= ERR_NONE;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bids22_cmd_seq.sv
// Self-checking bench for bids22_cmd_seq: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_bids22_cmd_seq;
    import bids22_pkg::*;

`ifdef BIDS_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        seq_clr;
    logic        ready;
    logic [1:0]  err;
    logic        round_over;
    logic [31:0] max_bid;
    logic        x_win, y_win, z_win;
    logic [3:0]  c_op;
    logic [31:0] c_data;
    logic        c_start;
    logic        res_valid;
    logic [31:0] res_maxbid;
    logic [1:0]  res_winner;
    logic [1:0]  seq_err;
    logic        busy;

    always #5 clk = ~clk;

    bids22_cmd_seq #(.DEPTH(8), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .seq_clr    (seq_clr),
        .ready      (ready),
        .err        (err),
        .roundOver  (round_over),
        .maxBid     (max_bid),
        .X_win      (x_win),
        .Y_win      (y_win),
        .Z_win      (z_win),
        .C_op       (c_op),
        .C_data     (c_data),
        .C_start    (c_start),
        .res_valid  (res_valid),
        .res_maxBid (res_maxbid),
        .res_winner (res_winner),
        .seq_err    (seq_err),
        .busy       (busy)
    );

    typedef struct packed {
        logic        cmd_ready;
        logic [3:0]  c_op;
        logic [31:0] c_data;
        logic        c_start;
        logic        busy;
        logic [1:0]  seq_err;
        logic        res_valid;
        logic [1:0]  res_winner;
        logic [31:0] res_maxbid;
    } out_t;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] data;
        logic        ro;
        logic [2:0]  win;
        logic [31:0] mb;
        out_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vec [17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid  = 1'b0;
        cmd_op     = 4'h0;
        cmd_data   = 32'h0;
        seq_clr    = 1'b0;
        err        = 2'b00;
        round_over = 1'b0;
        max_bid    = 32'h0;
        {x_win, y_win, z_win} = 3'b000;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cs(input logic lvl, input string name);
        int n = 0;
        while (c_start !== lvl && n < 20) begin
            tick();
            n++;
        end
        check(name, c_start, lvl);
    endtask

    // Winner from the rules: a single asserted flag wins, anything else is a tie.
    function automatic logic [1:0] ref_winner(input logic [2:0] w);
        if ($countones(w) != 1) return 2'd0;
        if (w[2]) return 2'd1;
        if (w[1]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.cmd_ready  = cmd_ready;
        o.c_op       = c_op;
        o.c_data     = c_data;
        o.c_start    = c_start;
        o.busy       = busy;
        o.seq_err    = seq_err;
        o.res_valid  = res_valid;
        o.res_winner = res_winner;
        o.res_maxbid = res_maxbid;
        return o;
    endfunction

    function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [31:0] d,
                                input logic ro, input logic [2:0] w, input logic [31:0] mb,
                                input logic [3:0] eop, input logic [31:0] ed, input logic ecs,
                                input logic eb, input logic erv, input logic [1:0] erw,
                                input logic [31:0] emb);
        vec_t t;
        t.valid = v; t.op = op; t.data = d; t.ro = ro; t.win = w; t.mb = mb;
        t.exp = '{cmd_ready: 1'b1, c_op: eop, c_data: ed, c_start: ecs, busy: eb,
                  seq_err: 2'b00, res_valid: erv, res_winner: erw, res_maxbid: emb};
        return t;
    endfunction

    initial begin
        logic [31:0] d1, d2;
        logic [35:0] got [$];
        logic [35:0] mq [$];
        logic        seen;
        out_t        rst_exp;

        d1 = 32'h100;
        d2 = 32'h0F0F_0F0F;
        // Each row: inputs for one cycle, outputs expected after the following edge.
        vec[0]  = mk(1, 4'h3, d1,    0, 3'b000, 0,     4'h0, 32'h0, 0, 1, 0, 0, 0);
        vec[1]  = mk(1, 4'h2, d2,    0, 3'b000, 0,     4'h0, 32'h0, 0, 1, 0, 0, 0);
        vec[2]  = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h3, d1,    0, 1, 0, 0, 0);
        vec[3]  = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h0, d1,    0, 1, 0, 0, 0);
        vec[4]  = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h0, d1,    0, 1, 0, 0, 0);
        vec[5]  = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h2, d2,    0, 1, 0, 0, 0);
        vec[6]  = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h0, d2,    0, 0, 0, 0, 0);
        vec[7]  = mk(1, 4'hF, 32'd5, 0, 3'b000, 0,     4'h0, d2,    0, 1, 0, 0, 0);
        vec[8]  = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h0, d2,    0, 1, 0, 0, 0);
        for (int i = 9; i <= 13; i++)
            vec[i] = mk(0, 4'h0, 0,  0, 3'b000, 0,     4'h0, d2,    1, 1, 0, 0, 0);
        vec[14] = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h0, d2,    0, 1, 0, 0, 0);
        vec[15] = mk(0, 4'h0, 0,     1, 3'b010, 32'h40, 4'h0, d2,   0, 0, 1, 2, 32'h40);
        vec[16] = mk(0, 4'h0, 0,     0, 3'b000, 0,     4'h0, d2,    0, 0, 0, 2, 32'h40);

        // Reset state
        idle_inputs();
        ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        rst_exp = '{cmd_ready: 1'b1, default: '0};
        check("reset outputs", sample(), rst_exp);
        reset = 1'b0;

        // Table: two config commands, then a 5-cycle round won by Y
        for (int i = 0; i < 17; i++) begin
            cmd_valid = vec[i].valid; cmd_op = vec[i].op; cmd_data = vec[i].data;
            round_over = vec[i].ro; {x_win, y_win, z_win} = vec[i].win; max_bid = vec[i].mb;
            tick();
            check($sformatf("vec[%0d]", i), sample(), vec[i].exp);
        end
        idle_inputs();
        tick();

        // Bad opcode halts; queued LoadY waits until seq_clr
        cmd_valid = 1'b1; cmd_op = 4'hA; cmd_data = 32'h0;
        tick();
        cmd_op = 4'h4; cmd_data = 32'h44;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("badop seq_err", seq_err, ERR_BAD_OP);
        check("badop c_op", c_op, 4'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (c_op != 4'h0) seen = 1'b1;
        end
        check("halt issues nothing", seen, 1'b0);
        check("halt busy", busy, 1'b1);
        seq_clr = 1'b1;
        tick();
        seq_clr = 1'b0;
        check("clr seq_err", seq_err, ERR_NONE);
        tick();
        check("clr issue c_op", c_op, 4'h0);
        tick();
        check("clr loady", {c_op, c_data}, {4'h4, 32'h44});
        tick();
        tick();

        // Auction error in the CHECK cycle after Unlock
        push_cmd(4'h1, 32'h55);
        tick();
        tick();
        check("unlock driven", {c_op, c_data}, {4'h1, 32'h55});
        err = 2'b01;
        tick();
        err = 2'b00;
        check("auction err seq_err", seq_err, ERR_AUCTION);
        check("auction err c_op", c_op, 4'h0);
        tick();
        check("auction err held", seq_err, ERR_AUCTION);
        seq_clr = 1'b1;
        tick();
        seq_clr = 1'b0;
        check("auction err cleared", {seq_err, busy}, 3'b000);

        // Fill while the auction is not ready; 9th push must be dropped
        ready = 1'b0;
        for (int i = 0; i < 8; i++) push_cmd(4'(i + 1), 32'h1000 + i);
        check("full cmd_ready", cmd_ready, 1'b0);
        push_cmd(4'h5, 32'hDEAD);
        check("full nothing issued", c_op, 4'h0);
        ready = 1'b1;
        got.delete();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (c_op != 4'h0) got.push_back({c_op, c_data});
        end
        check("full issued count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check($sformatf("full order[%0d]", i), got[i], {4'(i + 1), 32'h1000 + i});
        check("full drained busy", busy, 1'b0);

        // Result wait: timeout when enabled, indefinite wait otherwise
        push_cmd(4'hF, 32'd2);
        wait_cs(1'b1, "wait round start");
        wait_cs(1'b0, "wait round end");
`ifdef BIDS_SEQ_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("timeout not yet", seq_err, ERR_NONE);
        tick();
        if (res_valid) seen = 1'b1;
        check("timeout seq_err", seq_err, ERR_TIMEOUT);
        check("timeout no res_valid", seen, 1'b0);
        seq_clr = 1'b1;
        tick();
        seq_clr = 1'b0;
        check("timeout cleared", {seq_err, busy}, 3'b000);
`else
        for (int i = 0; i < 40; i++) tick();
        check("wait no err", seq_err, ERR_NONE);
        check("wait busy", busy, 1'b1);
        round_over = 1'b1; {x_win, y_win, z_win} = 3'b101; max_bid = 32'h77;
        tick();
        idle_inputs();
        check("tie result", {res_valid, res_winner, res_maxbid}, {1'b1, 2'd0, 32'h77});
        tick();
        check("tie done", {res_valid, busy}, 2'b00);
`endif

        // Randomized traffic against a command-order / round-length model
        begin
            int pushes = 0;
            int hi = 0;
            int exp_len = 0;
            int cd = -1;
            logic prev_cs = 1'b0;
            logic res_pend = 1'b0;
            logic [1:0] exp_w = '0;
            logic [31:0] exp_mb = '0;
            mq.delete();
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (res_pend) begin
                    check("rand result", {res_valid, res_winner, res_maxbid}, {1'b1, exp_w, exp_mb});
                    res_pend = 1'b0;
                end else if (res_valid) begin
                    check("rand stray res_valid", res_valid, 1'b0);
                end
                if (c_op != 4'h0) begin
                    if (mq.size() == 0 || mq[0][35:32] == 4'hF) check("rand stray c_op", c_op, 4'h0);
                    else begin
                        check("rand c_op", {c_op, c_data}, mq[0]);
                        void'(mq.pop_front());
                    end
                end
                if (c_start && !prev_cs) begin
                    hi = 0;
                    if (mq.size() == 0 || mq[0][35:32] != 4'hF) check("rand stray round", c_start, 1'b0);
                    else begin
                        exp_len = (mq[0][31:0] == 32'd0) ? 1 : int'(mq[0][31:0]);
                        void'(mq.pop_front());
                    end
                end
                if (c_start) hi++;
                if (!c_start && prev_cs) begin
                    check("rand round length", hi, exp_len);
                    cd = int'($urandom_range(0, 4));
                end
                prev_cs = c_start;
                if (pushes >= 50 && mq.size() == 0 && !busy && cd < 0 && !res_pend) break;

                round_over = 1'b0;
                {x_win, y_win, z_win} = 3'b000;
                if (cd == 0) begin
                    logic [2:0] w;
                    w = 3'($urandom);
                    max_bid = $urandom;
                    round_over = 1'b1;
                    {x_win, y_win, z_win} = w;
                    exp_w = ref_winner(w);
                    exp_mb = max_bid;
                    res_pend = 1'b1;
                    cd = -1;
                end else if (cd > 0) begin
                    cd--;
                end
                ready = ($urandom_range(0, 3) != 0);
                cmd_valid = 1'b0;
                if (pushes < 50 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cmd_op = 4'hF;
                        cmd_data = 32'($urandom_range(0, 6));
                    end else begin
                        cmd_op = 4'($urandom_range(1, 8));
                        cmd_data = $urandom;
                    end
                    cmd_valid = 1'b1;
                    if (cmd_ready) begin
                        mq.push_back({cmd_op, cmd_data});
                        pushes++;
                    end
                end
                tick();
            end
            idle_inputs();
            ready = 1'b1;
            check("rand drained", mq.size(), 0);
            check("rand idle", busy, 1'b0);
        end

        // Reset in the middle of a round discards the round and the queue
        push_cmd(4'hF, 32'd10);
        push_cmd(4'h3, 32'h5);
        wait_cs(1'b1, "mid-round start");
        tick();
        reset = 1'b1;
        tick();
        check("mid-reset outputs", {c_start, busy, cmd_ready, c_op}, {1'b0, 1'b0, 1'b1, 4'h0});
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (c_op != 4'h0 || c_start) seen = 1'b1;
        end
        check("mid-reset fifo discarded", seen, 1'b0);
        check("mid-reset idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
